matrix_bram_read_arbiter: RTL and testbench

//  Shares the single read port of the matrix-storage BRAM (8 slots x BLOCK_SIZE words) between
//  NUM_PORTS requesters: scanner, operand fetch, display readback. Round-robin per-beat

---
 rtl/matrix_bram_read_arbiter_pkg.sv | 27 ++
 rtl/matrix_bram_read_arbiter_rr_priority_pick.sv | 46 ++++
 rtl/matrix_bram_read_arbiter.sv | 133 +++++++++++++
 tb/tb_matrix_bram_read_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/matrix_bram_read_arbiter_pkg.sv
// Purpose: shared constants and types for the matrix-storage BRAM read arbiter.
//   Matrix storage geometry, requester port indices, arbiter state encoding
//   and a helper that sizes port-index fields.
package matrix_bram_read_arbiter_pkg;

  // Matrix storage geometry: 8 slots of BLOCK_SIZE words each.
  localparam int unsigned BLOCK_SIZE     = 1152;
  localparam int unsigned MAT_SLOTS      = 8;
  localparam int unsigned MAT_ADDR_WIDTH = 14;
  localparam int unsigned MAT_DATA_WIDTH = 32;

  // Requester port indices.
  localparam int unsigned PORT_SCANNER = 0;
  localparam int unsigned PORT_OPFETCH = 1;
  localparam int unsigned PORT_DISPLAY = 2;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Width of a field that indexes n ports; at least one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matrix_bram_read_arbiter_rr_priority_pick.sv
// Purpose: cyclic priority picker. Starting at ptr and wrapping, selects the
//   first asserted request. Purely combinational.
// Ports:
//   req    in  N   request vector
//   ptr    in  PW  search start index (must be < N)
//   grant  out N   one-hot winner (0 when no request)
//   idx    out PW  index of the winner
//   any    out 1   at least one request present
module rr_priority_pick
  import matrix_bram_read_arbiter_pkg::*;
#(
  parameter int unsigned N  = 3,
  parameter int unsigned PW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          any
);

  int unsigned   cand;
  logic [PW-1:0] cand_idx;

  // Walk N positions from ptr; the first hit wins.
  always_comb begin
    grant    = '0;
    idx      = '0;
    any      = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= N) begin
        cand = cand - N;
      end
      cand_idx = PW'(cand);
      if (!any && req[cand_idx]) begin
        any             = 1'b1;
        grant[cand_idx] = 1'b1;
        idx             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/matrix_bram_read_arbiter.sv
// Purpose: shares the single read port of the matrix-storage BRAM between
//   NUM_PORTS requesters (port 0 = scanner, 1 = operand fetch, 2 = display).
//   Round-robin per-beat arbitration, optional per-port lock for bursts,
//   fixed 2-cycle response latency with the data routed to the owner.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   req         per-port read request, held until granted
//   lock        per-port burst lock (keep grant while req stays high)
//   addr        flattened per-port word address, port i at [i*AW +: AW]
//   gnt         one-hot, combinational: request accepted this cycle
//   rvalid      one-hot pulse: rdata belongs to this port
//   rdata       shared read data (bram_data passthrough)
//   bram_en     BRAM read enable (registered)
//   bram_addr   BRAM word address (registered)
//   bram_data   BRAM output, valid one cycle after bram_en
module matrix_bram_read_arbiter
  import matrix_bram_read_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 3,
  parameter int unsigned ADDR_WIDTH = MAT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = MAT_DATA_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS-1:0]            req,
  input  logic [NUM_PORTS-1:0]            lock,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr,
  output logic [NUM_PORTS-1:0]            gnt,
  output logic [NUM_PORTS-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]           rdata,
  output logic                            bram_en,
  output logic [ADDR_WIDTH-1:0]           bram_addr,
  input  logic [DATA_WIDTH-1:0]           bram_data
);

  localparam int unsigned PW = idx_width(NUM_PORTS);

  arb_state_t             state;
  logic [PW-1:0]          rr_ptr;
  logic [PW-1:0]          lock_owner;
  logic [NUM_PORTS-1:0]   tag_q;

  logic [NUM_PORTS-1:0]   pick_gnt;
  logic [PW-1:0]          pick_idx;
  logic                   pick_any;

  logic                   owner_hold;
  logic [NUM_PORTS-1:0]   gnt_sel;
  logic [PW-1:0]          gnt_idx;
  logic                   gnt_any;
  logic [ADDR_WIDTH-1:0]  addr_mux;
  logic [PW-1:0]          ptr_next;

  rr_priority_pick #(
    .N  (NUM_PORTS),
    .PW (PW)
  ) u_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .grant (pick_gnt),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Grant select: a locked owner that still requests keeps the port; otherwise
  // the round-robin pick decides in the same cycle, so a dropped burst costs no bubble.
  always_comb begin
    owner_hold = (state == LOCKED) && req[lock_owner];
    gnt_sel    = pick_gnt;
    gnt_idx    = pick_idx;
    gnt_any    = pick_any;
    if (owner_hold) begin
      gnt_sel             = '0;
      gnt_sel[lock_owner] = 1'b1;
      gnt_idx             = lock_owner;
      gnt_any             = 1'b1;
    end
  end

  assign gnt = gnt_sel;

  // Address of the granted port.
  always_comb begin
    addr_mux = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (gnt_sel[i]) begin
        addr_mux = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // Round-robin pointer moves to the port after the winner.
  always_comb begin
    ptr_next = (gnt_idx == PW'(NUM_PORTS - 1)) ? '0 : gnt_idx + PW'(1);
  end

  // Arbiter state, BRAM request register and 2-stage response tag pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB;
      rr_ptr     <= '0;
      lock_owner <= '0;
      bram_en    <= 1'b0;
      bram_addr  <= '0;
      tag_q      <= '0;
      rvalid     <= '0;
    end else begin
      bram_en <= gnt_any;
      tag_q   <= gnt_sel;
      rvalid  <= tag_q;
      if (gnt_any) begin
        bram_addr <= addr_mux;
        rr_ptr    <= ptr_next;
        if (lock[gnt_idx]) begin
          state      <= LOCKED;
          lock_owner <= gnt_idx;
        end else begin
          state <= ARB;
        end
      end else begin
        state <= ARB;
      end
    end
  end

  // Data is not gated: it is only meaningful while some rvalid bit is set.
  assign rdata = bram_data;

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_rvalid_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(rvalid));
  a_gnt_has_req: assert property (@(posedge clk) disable iff (!rst_n) (gnt & ~req) == '0);

endmodule

// File: tb/tb_matrix_bram_read_arbiter.sv
// Purpose: self-checking bench for matrix_bram_read_arbiter (3 ports).
//   Per-cycle directed vector table plus a hand-written reset-mid-burst sequence.
module tb_matrix_bram_read_arbiter;
  import matrix_bram_read_arbiter_pkg::*;

  localparam int unsigned NP = 3;
  localparam int unsigned AW = MAT_ADDR_WIDTH;
  localparam int unsigned DW = MAT_DATA_WIDTH;
  localparam int unsigned NV = 36;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NP-1:0]    req;
  logic [NP-1:0]    lock;
  logic [NP*AW-1:0] addr;
  logic [NP-1:0]    gnt;
  logic [NP-1:0]    rvalid;
  logic [DW-1:0]    rdata;
  logic             bram_en;
  logic [AW-1:0]    bram_addr;
  logic [DW-1:0]    bram_data = '0;

  int n_checks = 0;
  int n_pass   = 0;

  matrix_bram_read_arbiter #(
    .NUM_PORTS  (NP),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .lock      (lock),
    .addr      (addr),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .bram_en   (bram_en),
    .bram_addr (bram_addr),
    .bram_data (bram_data)
  );

  always #5 clk = ~clk;

  // BRAM model: word at address a reads back as 0x0303_0000 | a.
  function automatic logic [DW-1:0] bram_word(input logic [AW-1:0] a);
    return 32'h0303_0000 | 32'(a);
  endfunction

  always @(posedge clk) begin
    if (bram_en) bram_data <= bram_word(bram_addr);
  end

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  lock;
    logic [13:0] a0;
    logic [13:0] a1;
    logic [13:0] a2;
    logic [2:0]  gnt;
    logic        en;
    logic [13:0] baddr;
    logic [2:0]  rv;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl [NV];

  function automatic vec_t mk(input logic [2:0] r, input logic [2:0] l,
                              input logic [13:0] a0, input logic [13:0] a1, input logic [13:0] a2,
                              input logic [2:0] g, input logic e, input logic [13:0] ba,
                              input logic [2:0] rv, input logic [31:0] rd);
    vec_t v;
    v.req = r; v.lock = l; v.a0 = a0; v.a1 = a1; v.a2 = a2;
    v.gnt = g; v.en = e; v.baddr = ba; v.rv = rv; v.rdata = rd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic [2:0] r, input logic [2:0] l,
                       input logic [13:0] a0, input logic [13:0] a1, input logic [13:0] a2);
    req  = r;
    lock = l;
    addr = {a2, a1, a0};
  endtask

  initial begin
    // Single port 0, then port 2 to wrap rr_ptr back to 0.
    tbl[0]  = mk(3'b001, 3'b000, 14'h0000, 14'h0, 14'h0,  3'b001, 1'b0, 14'h0000, 3'b000, 32'h0);
    tbl[1]  = mk(3'b000, 3'b000, 14'h0000, 14'h0, 14'h0,  3'b000, 1'b1, 14'h0000, 3'b000, 32'h0);
    tbl[2]  = mk(3'b000, 3'b000, 14'h0000, 14'h0, 14'h0,  3'b000, 1'b0, 14'h0000, 3'b001, 32'h0303_0000);
    tbl[3]  = mk(3'b100, 3'b000, 14'h0000, 14'h0, 14'h5,  3'b100, 1'b0, 14'h0000, 3'b000, 32'h0);
    tbl[4]  = mk(3'b000, 3'b000, 14'h0000, 14'h0, 14'h0,  3'b000, 1'b1, 14'h0005, 3'b000, 32'h0);
    tbl[5]  = mk(3'b000, 3'b000, 14'h0000, 14'h0, 14'h0,  3'b000, 1'b0, 14'h0005, 3'b100, 32'h0303_0005);
    // All three requesting, no lock: 0,1,2,0,1,2.
    tbl[6]  = mk(3'b111, 3'b000, 14'h0010, 14'h20, 14'h30, 3'b001, 1'b0, 14'h0005, 3'b000, 32'h0);
    tbl[7]  = mk(3'b111, 3'b000, 14'h0010, 14'h20, 14'h30, 3'b010, 1'b1, 14'h0010, 3'b000, 32'h0);
    tbl[8]  = mk(3'b111, 3'b000, 14'h0010, 14'h20, 14'h30, 3'b100, 1'b1, 14'h0020, 3'b001, 32'h0303_0010);
    tbl[9]  = mk(3'b111, 3'b000, 14'h0010, 14'h20, 14'h30, 3'b001, 1'b1, 14'h0030, 3'b010, 32'h0303_0020);
    tbl[10] = mk(3'b111, 3'b000, 14'h0010, 14'h20, 14'h30, 3'b010, 1'b1, 14'h0010, 3'b100, 32'h0303_0030);
    tbl[11] = mk(3'b111, 3'b000, 14'h0010, 14'h20, 14'h30, 3'b100, 1'b1, 14'h0020, 3'b001, 32'h0303_0010);
    tbl[12] = mk(3'b000, 3'b000, 14'h0000, 14'h0, 14'h0,  3'b000, 1'b1, 14'h0030, 3'b010, 32'h0303_0020);
    tbl[13] = mk(3'b000, 3'b000, 14'h0000, 14'h0, 14'h0,  3'b000, 1'b0, 14'h0030, 3'b100, 32'h0303_0030);
    // Port 1 locked burst 1152..1155 with ports 0/2 waiting, then 2, then 0.
    tbl[14] = mk(3'b010, 3'b010, 14'h0000, 14'h480, 14'h0,  3'b010, 1'b0, 14'h0030, 3'b000, 32'h0);
    tbl[15] = mk(3'b111, 3'b010, 14'h0011, 14'h481, 14'h31, 3'b010, 1'b1, 14'h0480, 3'b000, 32'h0);
    tbl[16] = mk(3'b111, 3'b010, 14'h0011, 14'h482, 14'h31, 3'b010, 1'b1, 14'h0481, 3'b010, 32'h0303_0480);
    tbl[17] = mk(3'b111, 3'b010, 14'h0011, 14'h483, 14'h31, 3'b010, 1'b1, 14'h0482, 3'b010, 32'h0303_0481);
    tbl[18] = mk(3'b101, 3'b000, 14'h0011, 14'h000, 14'h31, 3'b100, 1'b1, 14'h0483, 3'b010, 32'h0303_0482);
    tbl[19] = mk(3'b001, 3'b000, 14'h0011, 14'h000, 14'h00, 3'b001, 1'b1, 14'h0031, 3'b010, 32'h0303_0483);
    tbl[20] = mk(3'b000, 3'b000, 14'h0000, 14'h0, 14'h0,  3'b000, 1'b1, 14'h0011, 3'b100, 32'h0303_0031);
    tbl[21] = mk(3'b000, 3'b000, 14'h0000, 14'h0, 14'h0,  3'b000, 1'b0, 14'h0011, 3'b001, 32'h0303_0011);
    // Lock release on beat 2 with port 0 waiting: port 0 next, no bubble.
    tbl[22] = mk(3'b011, 3'b010, 14'h0040, 14'h50, 14'h0,  3'b010, 1'b0, 14'h0011, 3'b000, 32'h0);
    tbl[23] = mk(3'b011, 3'b000, 14'h0040, 14'h51, 14'h0,  3'b010, 1'b1, 14'h0050, 3'b000, 32'h0);
    tbl[24] = mk(3'b001, 3'b000, 14'h0040, 14'h00, 14'h0,  3'b001, 1'b1, 14'h0051, 3'b010, 32'h0303_0050);
    tbl[25] = mk(3'b000, 3'b000, 14'h0000, 14'h0, 14'h0,  3'b000, 1'b1, 14'h0040, 3'b010, 32'h0303_0051);
    tbl[26] = mk(3'b000, 3'b000, 14'h0000, 14'h0, 14'h0,  3'b000, 1'b0, 14'h0040, 3'b001, 32'h0303_0040);
    // Idle gaps: bram_en low, rr_ptr held across gaps.
    tbl[27] = mk(3'b000, 3'b000, 14'h0000, 14'h0, 14'h0,  3'b000, 1'b0, 14'h0040, 3'b000, 32'h0);
    tbl[28] = mk(3'b100, 3'b000, 14'h0000, 14'h0, 14'h60, 3'b100, 1'b0, 14'h0040, 3'b000, 32'h0);
    tbl[29] = mk(3'b000, 3'b000, 14'h0000, 14'h0, 14'h0,  3'b000, 1'b1, 14'h0060, 3'b000, 32'h0);
    tbl[30] = mk(3'b000, 3'b000, 14'h0000, 14'h0, 14'h0,  3'b000, 1'b0, 14'h0060, 3'b100, 32'h0303_0060);
    tbl[31] = mk(3'b000, 3'b000, 14'h0000, 14'h0, 14'h0,  3'b000, 1'b0, 14'h0060, 3'b000, 32'h0);
    tbl[32] = mk(3'b011, 3'b000, 14'h0070, 14'h71, 14'h0,  3'b001, 1'b0, 14'h0060, 3'b000, 32'h0);
    tbl[33] = mk(3'b010, 3'b000, 14'h0000, 14'h71, 14'h0,  3'b010, 1'b1, 14'h0070, 3'b000, 32'h0);
    tbl[34] = mk(3'b000, 3'b000, 14'h0000, 14'h0, 14'h0,  3'b000, 1'b1, 14'h0071, 3'b001, 32'h0303_0070);
    tbl[35] = mk(3'b000, 3'b000, 14'h0000, 14'h0, 14'h0,  3'b000, 1'b0, 14'h0071, 3'b010, 32'h0303_0071);

    rst_n = 1'b0;
    drive(3'b000, 3'b000, 14'h0, 14'h0, 14'h0);
    @(negedge clk);
    check("reset gnt", 32'(gnt), 32'h0);
    check("reset rvalid", 32'(rvalid), 32'h0);
    check("reset bram_en", 32'(bram_en), 32'h0);
    check("reset bram_addr", 32'(bram_addr), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < int'(NV); i++) begin
      drive(tbl[i].req, tbl[i].lock, tbl[i].a0, tbl[i].a1, tbl[i].a2);
      @(negedge clk);
      check($sformatf("c%0d gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      check($sformatf("c%0d bram_en", i), 32'(bram_en), 32'(tbl[i].en));
      check($sformatf("c%0d bram_addr", i), 32'(bram_addr), 32'(tbl[i].baddr));
      check($sformatf("c%0d rvalid", i), 32'(rvalid), 32'(tbl[i].rv));
      if (tbl[i].rv != 3'b000) check($sformatf("c%0d rdata", i), rdata, tbl[i].rdata);
      @(posedge clk); #1;
    end

    // Reset one cycle after a locked grant: the beat is dropped, state cleared.
    drive(3'b001, 3'b001, 14'h0090, 14'h0, 14'h0);
    @(negedge clk);
    check("rst T gnt", 32'(gnt), 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive(3'b000, 3'b000, 14'h0, 14'h0, 14'h0);
    @(negedge clk);
    check("rst T+1 bram_en", 32'(bram_en), 32'h0);
    check("rst T+1 bram_addr", 32'(bram_addr), 32'h0);
    check("rst T+1 gnt", 32'(gnt), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst T+2 rvalid", 32'(rvalid), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(3'b111, 3'b000, 14'h0091, 14'h92, 14'h93);
    @(negedge clk);
    check("post-rst gnt rr_ptr=0", 32'(gnt), 32'h1);
    check("post-rst rvalid", 32'(rvalid), 32'h0);
    @(posedge clk); #1;
    drive(3'b000, 3'b000, 14'h0, 14'h0, 14'h0);
    @(negedge clk);
    check("post-rst bram_en", 32'(bram_en), 32'h1);
    check("post-rst bram_addr", 32'(bram_addr), 32'h91);
    check("post-rst no stale rvalid", 32'(rvalid), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("post-rst rvalid", 32'(rvalid), 32'h1);
    check("post-rst rdata", rdata, 32'h0303_0091);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
